// File: rtl/ats_eligibility_time_assigner.sv
// ---------------------------------------------------------------------------
// ats_eligibility_time_assigner
//
// Per-stream ATS token-bucket shaper (802.1Qcr eligibility-time assignment).
// Each accepted frame descriptor {arrival_time, frame_length} is turned into
// an eligibility timestamp on an AXI4-Stream channel. Frames whose residence
// would exceed max_residence_time are flagged for discard (tuser=1) and do
// not update the shaper state.
//
// Ports:
//   clk, rstn                              clock, async active-low reset
//   length_recovery_ns_per_byte            1/CIR in ns per byte (static)
//   empty_to_full_duration                 CBS/CIR in ns (static)
//   max_residence_time                     max (eligibility - arrival) in ns
//   s_axis_frame_info_*                    descriptor input, length in LSBs
//   m_axis_eligibility_timestamp_*         eligibility time, tuser = discard
//
// Timing: descriptor accepted at edge N -> result valid after edge N+2.
// One descriptor per four cycles; a stalled output stalls the input.
// ---------------------------------------------------------------------------
module ats_eligibility_time_assigner #(
    parameter int TIMESTAMP_WIDTH    = 72,
    parameter int FRAME_LENGTH_WIDTH = 16,
    parameter int RATE_WIDTH         = 16
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic [RATE_WIDTH-1:0]                       length_recovery_ns_per_byte,
    input  logic [TIMESTAMP_WIDTH-1:0]                  empty_to_full_duration,
    input  logic [TIMESTAMP_WIDTH-1:0]                  max_residence_time,
    input  logic [FRAME_LENGTH_WIDTH+TIMESTAMP_WIDTH-1:0] s_axis_frame_info_tdata,
    input  logic                                        s_axis_frame_info_tvalid,
    output logic                                        s_axis_frame_info_tready,
    output logic [TIMESTAMP_WIDTH-1:0]                  m_axis_eligibility_timestamp_tdata,
    output logic                                        m_axis_eligibility_timestamp_tuser,
    output logic                                        m_axis_eligibility_timestamp_tvalid,
    input  logic                                        m_axis_eligibility_timestamp_tready
);

    localparam int PRODUCT_WIDTH = FRAME_LENGTH_WIDTH + RATE_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        DECIDE  = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Latched descriptor
    logic [FRAME_LENGTH_WIDTH-1:0] frame_length_q;
    logic [TIMESTAMP_WIDTH-1:0]    arrival_q;

    // Values computed in RECOVER and consumed in DECIDE
    logic [TIMESTAMP_WIDTH-1:0]    length_recovery_q;
    logic [TIMESTAMP_WIDTH-1:0]    scheduler_eligibility_q;
    logic [TIMESTAMP_WIDTH-1:0]    bucket_full_time_q;

    // Persistent shaper state
    logic [TIMESTAMP_WIDTH-1:0]    bucket_empty_time;
    logic [TIMESTAMP_WIDTH-1:0]    group_eligibility_time;

    // Combinational datapath
    logic [PRODUCT_WIDTH-1:0]      length_product;
    logic [TIMESTAMP_WIDTH-1:0]    length_recovery;
    logic [TIMESTAMP_WIDTH-1:0]    eligibility;
    logic [TIMESTAMP_WIDTH-1:0]    arrival_or_group;
    logic [TIMESTAMP_WIDTH-1:0]    residence_limit;
    logic [TIMESTAMP_WIDTH-1:0]    next_bucket_empty_time;
    logic                          within_residence;

    logic                          accept;
    logic                          out_fire;

    assign accept   = s_axis_frame_info_tvalid & s_axis_frame_info_tready;
    assign out_fire = m_axis_eligibility_timestamp_tvalid & m_axis_eligibility_timestamp_tready;

    // Recovery time of the frame: bytes times ns-per-byte, zero-extended to
    // the timestamp width.
    always_comb begin
        length_product  = PRODUCT_WIDTH'(frame_length_q) * PRODUCT_WIDTH'(length_recovery_ns_per_byte);
        length_recovery = TIMESTAMP_WIDTH'(length_product);
    end

    // Eligibility is the latest of arrival, the group's last eligibility and
    // the time the bucket holds enough tokens. When the bucket would have
    // overflowed (eligibility at or past the full time) the excess tokens
    // are lost, which pushes the empty time forward by the overflow amount.
    always_comb begin
        arrival_or_group = (arrival_q > group_eligibility_time) ? arrival_q
                                                                : group_eligibility_time;
        eligibility      = (arrival_or_group > scheduler_eligibility_q) ? arrival_or_group
                                                                        : scheduler_eligibility_q;
        residence_limit  = arrival_q + max_residence_time;
        within_residence = (eligibility <= residence_limit);
        if (eligibility < bucket_full_time_q) begin
            next_bucket_empty_time = scheduler_eligibility_q;
        end else begin
            next_bucket_empty_time = scheduler_eligibility_q + (eligibility - bucket_full_time_q);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = RECOVER;
                end
            end
            RECOVER: next_state = DECIDE;
            DECIDE:  next_state = OUTPUT;
            OUTPUT: begin
                if (out_fire) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Input ready is registered so it stays low throughout reset and rises
    // on the first clock after rstn deasserts; otherwise it tracks IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_axis_frame_info_tready <= 1'b0;
        end else begin
            s_axis_frame_info_tready <= (next_state == IDLE);
        end
    end

    // Datapath: descriptor capture, recovery step, decision and output hold.
    // A discarded frame leaves the bucket and group state untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_length_q                      <= '0;
            arrival_q                           <= '0;
            length_recovery_q                   <= '0;
            scheduler_eligibility_q             <= '0;
            bucket_full_time_q                  <= '0;
            bucket_empty_time                   <= '0;
            group_eligibility_time              <= '0;
            m_axis_eligibility_timestamp_tdata  <= '0;
            m_axis_eligibility_timestamp_tuser  <= 1'b0;
            m_axis_eligibility_timestamp_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame_length_q <= s_axis_frame_info_tdata[FRAME_LENGTH_WIDTH-1:0];
                        arrival_q      <= s_axis_frame_info_tdata[FRAME_LENGTH_WIDTH +: TIMESTAMP_WIDTH];
                    end
                end
                RECOVER: begin
                    length_recovery_q       <= length_recovery;
                    scheduler_eligibility_q <= bucket_empty_time + length_recovery;
                    bucket_full_time_q      <= bucket_empty_time + empty_to_full_duration;
                end
                DECIDE: begin
                    m_axis_eligibility_timestamp_tdata  <= eligibility;
                    m_axis_eligibility_timestamp_tuser  <= ~within_residence;
                    m_axis_eligibility_timestamp_tvalid <= 1'b1;
                    if (within_residence) begin
                        group_eligibility_time <= eligibility;
                        bucket_empty_time      <= next_bucket_empty_time;
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        m_axis_eligibility_timestamp_tvalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The registered recovery term is kept for observability of the last
    // frame's token cost; it does not feed back into the decision.
    logic unused_length_recovery;
    assign unused_length_recovery = ^length_recovery_q;

endmodule

// File: tb/tb_ats_eligibility_time_assigner.sv
// ---------------------------------------------------------------------------
// tb_ats_eligibility_time_assigner
//
// Self-checking bench for ats_eligibility_time_assigner. A table of frame
// descriptors with hand-computed eligibility results is driven in a loop;
// expected results are queued when a descriptor is driven and popped when
// the DUT presents its output. Hand-written sequences cover output stall
// and reset in the middle of a computation.
// ---------------------------------------------------------------------------
module tb_ats_eligibility_time_assigner;

    localparam int TW  = 72;
    localparam int FLW = 16;
    localparam int RW  = 16;

    logic              clk;
    logic              rstn;
    logic [RW-1:0]     length_recovery_ns_per_byte;
    logic [TW-1:0]     empty_to_full_duration;
    logic [TW-1:0]     max_residence_time;
    logic [FLW+TW-1:0] s_axis_frame_info_tdata;
    logic              s_axis_frame_info_tvalid;
    logic              s_axis_frame_info_tready;
    logic [TW-1:0]     m_axis_eligibility_timestamp_tdata;
    logic              m_axis_eligibility_timestamp_tuser;
    logic              m_axis_eligibility_timestamp_tvalid;
    logic              m_axis_eligibility_timestamp_tready;

    ats_eligibility_time_assigner #(
        .TIMESTAMP_WIDTH    (TW),
        .FRAME_LENGTH_WIDTH (FLW),
        .RATE_WIDTH         (RW)
    ) dut (
        .clk                                 (clk),
        .rstn                                (rstn),
        .length_recovery_ns_per_byte         (length_recovery_ns_per_byte),
        .empty_to_full_duration              (empty_to_full_duration),
        .max_residence_time                  (max_residence_time),
        .s_axis_frame_info_tdata             (s_axis_frame_info_tdata),
        .s_axis_frame_info_tvalid            (s_axis_frame_info_tvalid),
        .s_axis_frame_info_tready            (s_axis_frame_info_tready),
        .m_axis_eligibility_timestamp_tdata  (m_axis_eligibility_timestamp_tdata),
        .m_axis_eligibility_timestamp_tuser  (m_axis_eligibility_timestamp_tuser),
        .m_axis_eligibility_timestamp_tvalid (m_axis_eligibility_timestamp_tvalid),
        .m_axis_eligibility_timestamp_tready (m_axis_eligibility_timestamp_tready)
    );

    typedef struct {
        logic [FLW-1:0] len;
        logic [TW-1:0]  arrival;
        logic [TW-1:0]  max_res;
        logic [TW-1:0]  exp_tdata;
        logic           exp_tuser;
    } vec_t;

    typedef struct {
        logic [TW-1:0] tdata;
        logic          tuser;
    } exp_t;

    vec_t vectors[11];
    exp_t scoreboard[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [TW-1:0] actual,
                              input logic [TW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one descriptor starting at a negedge; returns at the negedge
    // right after the accepting posedge. Optionally queues the expected result.
    task automatic applyStimulus(input logic [FLW-1:0] len, input logic [TW-1:0] arrival,
                                 input bit push, input logic [TW-1:0] exp_tdata,
                                 input logic exp_tuser);
        int waited;
        exp_t e;
        waited = 0;
        s_axis_frame_info_tdata  = {arrival, len};
        s_axis_frame_info_tvalid = 1'b1;
        while (!s_axis_frame_info_tready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!s_axis_frame_info_tready) begin
            checkValue("accept_timeout", 0, 1);
        end else begin
            if (push) begin
                e.tdata = exp_tdata;
                e.tuser = exp_tuser;
                scoreboard.push_back(e);
            end
            @(negedge clk);
        end
        s_axis_frame_info_tvalid = 1'b0;
    endtask

    // Wait (bounded) for a result, compare it with the scoreboard head and
    // let it transfer; optionally check the two-cycle result latency.
    task automatic checkOutput(input bit check_latency);
        int waited;
        exp_t e;
        waited = 0;
        m_axis_eligibility_timestamp_tready = 1'b1;
        while (!m_axis_eligibility_timestamp_tvalid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!m_axis_eligibility_timestamp_tvalid) begin
            checkValue("output_timeout", 0, 1);
            return;
        end
        if (check_latency) checkValue("latency", TW'(waited), 2);
        if (scoreboard.size() == 0) begin
            checkValue("scoreboard_empty", 0, 1);
        end else begin
            e = scoreboard.pop_front();
            checkValue("tdata", m_axis_eligibility_timestamp_tdata, e.tdata);
            checkValue("tuser", TW'(m_axis_eligibility_timestamp_tuser), TW'(e.tuser));
        end
        @(negedge clk);
        checkValue("tvalid_after_transfer", TW'(m_axis_eligibility_timestamp_tvalid), 0);
    endtask

    initial begin
        logic [TW-1:0] held_data;
        logic          held_user;
        int            bad;
        int            waited;
        exp_t          e;

        // len, arrival, max_res, expected tdata, expected tuser
        vectors[0]  = '{16'd100,  72'd5000,  72'd10000, 72'd5000,  1'b0};
        vectors[1]  = '{16'd100,  72'd5000,  72'd10000, 72'd5600,  1'b0};
        vectors[2]  = '{16'd1500, 72'd5000,  72'd10000, 72'd17600, 1'b1};
        vectors[3]  = '{16'd100,  72'd5000,  72'd10000, 72'd6400,  1'b0};
        vectors[4]  = '{16'd0,    72'd7000,  72'd10000, 72'd7000,  1'b0};
        vectors[5]  = '{16'd0,    72'd6000,  72'd10000, 72'd7000,  1'b0};
        vectors[6]  = '{16'd50,   72'd20000, 72'd10000, 72'd20000, 1'b0};
        vectors[7]  = '{16'd125,  72'd20000, 72'd10000, 72'd20400, 1'b0};
        vectors[8]  = '{16'd0,    72'd20400, 72'd0,     72'd20400, 1'b0};
        vectors[9]  = '{16'd1,    72'd20400, 72'd0,     72'd20408, 1'b1};
        vectors[10] = '{16'd0,    72'd30000, 72'd0,     72'd30000, 1'b0};

        rstn                                = 1'b0;
        length_recovery_ns_per_byte         = 16'd8;
        empty_to_full_duration              = 72'd1000;
        max_residence_time                  = 72'd10000;
        s_axis_frame_info_tdata             = '0;
        s_axis_frame_info_tvalid            = 1'b0;
        m_axis_eligibility_timestamp_tready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        checkValue("reset_s_tready", TW'(s_axis_frame_info_tready), 0);
        checkValue("reset_m_tvalid", TW'(m_axis_eligibility_timestamp_tvalid), 0);
        checkValue("reset_m_tdata", m_axis_eligibility_timestamp_tdata, 0);
        rstn = 1'b1;
        @(negedge clk);
        checkValue("ready_after_reset", TW'(s_axis_frame_info_tready), 1);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            max_residence_time = vectors[i].max_res;
            applyStimulus(vectors[i].len, vectors[i].arrival, 1'b1,
                          vectors[i].exp_tdata, vectors[i].exp_tuser);
            checkValue("s_tready_busy", TW'(s_axis_frame_info_tready), 0);
            checkOutput(1'b1);
        end

        // Output stall with a new descriptor pending on the input
        max_residence_time = 72'd10000;
        m_axis_eligibility_timestamp_tready = 1'b0;
        applyStimulus(16'd100, 72'd31000, 1'b1, 72'd31000, 1'b0);
        s_axis_frame_info_tdata  = {72'd32000, 16'd0};
        s_axis_frame_info_tvalid = 1'b1;
        waited = 0;
        while (!m_axis_eligibility_timestamp_tvalid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkValue("stall_tvalid", TW'(m_axis_eligibility_timestamp_tvalid), 1);
        held_data = m_axis_eligibility_timestamp_tdata;
        held_user = m_axis_eligibility_timestamp_tuser;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_axis_eligibility_timestamp_tdata !== held_data ||
                m_axis_eligibility_timestamp_tuser !== held_user ||
                m_axis_eligibility_timestamp_tvalid !== 1'b1 ||
                s_axis_frame_info_tready !== 1'b0) bad++;
        end
        checkValue("stall_hold_violations", TW'(bad), 0);
        if (scoreboard.size() == 0) begin
            checkValue("scoreboard_empty", 0, 1);
        end else begin
            e = scoreboard.pop_front();
            checkValue("stall_tdata", held_data, e.tdata);
            checkValue("stall_tuser", TW'(held_user), TW'(e.tuser));
        end
        m_axis_eligibility_timestamp_tready = 1'b1;
        @(negedge clk);
        checkValue("single_transfer_tvalid", TW'(m_axis_eligibility_timestamp_tvalid), 0);
        checkValue("idle_after_release", TW'(s_axis_frame_info_tready), 1);
        e.tdata = 72'd32000;
        e.tuser = 1'b0;
        scoreboard.push_back(e);
        @(negedge clk);
        s_axis_frame_info_tvalid = 1'b0;
        checkValue("pending_accepted", TW'(s_axis_frame_info_tready), 0);
        checkOutput(1'b1);

        // Reset while in RECOVER: descriptor lost, state cleared
        applyStimulus(16'd100, 72'd5000, 1'b0, 72'd0, 1'b0);
        rstn = 1'b0;
        #1;
        checkValue("midreset_m_tvalid", TW'(m_axis_eligibility_timestamp_tvalid), 0);
        checkValue("midreset_m_tdata", m_axis_eligibility_timestamp_tdata, 0);
        checkValue("midreset_m_tuser", TW'(m_axis_eligibility_timestamp_tuser), 0);
        checkValue("midreset_s_tready", TW'(s_axis_frame_info_tready), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkValue("ready_after_midreset", TW'(s_axis_frame_info_tready), 1);
        applyStimulus(16'd100, 72'd5000, 1'b1, 72'd5000, 1'b0);
        checkOutput(1'b1);
        applyStimulus(16'd100, 72'd5000, 1'b1, 72'd5600, 1'b0);
        checkOutput(1'b1);

        checkValue("scoreboard_drained", TW'(scoreboard.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
